// File: rtl/instr_queue.sv
// instr_queue: decode-side FIFO of instruction/PC pairs between fetch and decode.
// Absorbs decode stalls and discards everything on a branch redirect.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [XLEN-1:0]          instr_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [XLEN-1:0]          instr_out,
  output logic [XLEN-1:0]          pc_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            push, pop;

  // Handshakes depend only on registered occupancy, so a full queue never
  // accepts in the same cycle decode drains it (no ready_in -> ready_out path).
  assign ready_out = (count != FULL);
  assign valid_out = (count != '0);
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && ready_in;

  assign head      = mem[rd_ptr];
  assign instr_out = valid_out ? head.instr : '0;
  assign pc_out    = valid_out ? head.pc    : '0;

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; not cleared, occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= '{instr: instr_in, pc: pc_in};
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: queue-based reference model, per-cycle compare plus directed pins.
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk = 0;
  logic             reset, flush, valid_in, ready_in;
  logic [XLEN-1:0]  instr_in, pc_in;
  logic             ready_out, valid_out;
  logic [XLEN-1:0]  instr_out, pc_out;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  bit en = 0;

  typedef struct { logic [XLEN-1:0] instr; logic [XLEN-1:0] pc; } ent_t;
  ent_t q[$];

  logic [XLEN-1:0] imem [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h002081b3,
                                32'h00302023, 32'h00002203, 32'hfe0008e3, 32'h0000006f};

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instr_in(instr_in), .pc_in(pc_in),
    .valid_in(valid_in), .ready_out(ready_out), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .ready_in(ready_in), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Advance one edge and apply the specified queue semantics to the model.
  task automatic tick();
    bit pu, po;
    @(posedge clk);
    pu = valid_in && (q.size() < DEPTH);
    po = ready_in && (q.size() > 0);
    if (!reset || flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back('{instr: instr_in, pc: pc_in});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins);
    valid_in = v; pc_in = pc; instr_in = ins;
  endtask

  // Whole-interface comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (en) begin
      chk("count", 80'(count), 80'(q.size()));
      chk("valid_out", 80'(valid_out), 80'(q.size() != 0));
      chk("ready_out", 80'(ready_out), 80'(q.size() != DEPTH));
      chk("pc_out", 80'(pc_out), 80'(q.size() != 0 ? q[0].pc : '0));
      chk("instr_out", 80'(instr_out), 80'(q.size() != 0 ? q[0].instr : '0));
    end
  end

  initial begin
    logic [XLEN-1:0] pcr;
    reset = 0; flush = 0; ready_in = 0;
    drive(1, 32'h0, 32'h00000013);
    // 1. reset with valid_in high
    tick(); en = 1;
    tick();
    chk("rst_valid", 80'(valid_out), 80'(0));
    chk("rst_ready", 80'(ready_out), 80'(1));
    chk("rst_count", 80'(count), 80'(0));
    chk("rst_instr", 80'(instr_out), 80'(0));
    chk("rst_pc", 80'(pc_out), 80'(0));
    reset = 1;
    tick();
    drive(0, '0, '0);
    chk("first_valid", 80'(valid_out), 80'(1));
    chk("first_pc", 80'(pc_out), 80'(0));
    chk("first_instr", 80'(instr_out), 80'(32'h00000013));
    ready_in = 1; tick();
    // 2. streaming
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'(4*i), imem[i]); tick();
      chk("stream_count", 80'(count), 80'(1));
      chk("stream_pc", 80'(pc_out), 80'(4*i));
    end
    drive(0, '0, '0); tick();
    // 3. backpressure
    ready_in = 0;
    for (int i = 0; i < 4; i++) begin drive(1, 32'(4*i), imem[i]); tick(); end
    chk("full_count", 80'(count), 80'(4));
    chk("full_ready", 80'(ready_out), 80'(0));
    drive(1, 32'h10, imem[4]); tick();
    chk("held_count", 80'(count), 80'(4));
    chk("held_pc", 80'(pc_out), 80'(0));
    // 4. full with simultaneous pop: pop only, then push+pop
    ready_in = 1; tick();
    chk("fullpop_count", 80'(count), 80'(3));
    chk("fullpop_pc", 80'(pc_out), 80'(32'h4));
    tick();
    chk("pushpop_count", 80'(count), 80'(3));
    chk("pushpop_pc", 80'(pc_out), 80'(32'h8));
    drive(0, '0, '0);
    tick(); chk("drain_pc0", 80'(pc_out), 80'(32'hC));
    tick(); chk("drain_pc1", 80'(pc_out), 80'(32'h10));
    tick(); chk("drain_empty", 80'(valid_out), 80'(0));
    // 5. flush with same-cycle push/pop
    ready_in = 0;
    for (int i = 0; i < 3; i++) begin drive(1, 32'(32'h20 + 4*i), imem[i]); tick(); end
    chk("preflush_count", 80'(count), 80'(3));
    flush = 1; ready_in = 1; drive(1, 32'h2C, imem[3]); tick();
    flush = 0; ready_in = 0;
    chk("flush_count", 80'(count), 80'(0));
    chk("flush_valid", 80'(valid_out), 80'(0));
    chk("flush_ready", 80'(ready_out), 80'(1));
    drive(1, 32'h100, imem[5]); tick();
    chk("postflush_pc0", 80'(pc_out), 80'(32'h100));
    drive(1, 32'h104, imem[6]); tick();
    drive(0, '0, '0); ready_in = 1; tick();
    chk("postflush_pc1", 80'(pc_out), 80'(32'h104));
    tick();
    // 6. random traffic across pointer wrap
    pcr = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pcr, $urandom());
      ready_in = $urandom_range(0, 1);
      flush = ($urandom_range(0, 63) == 0);
      tick();
      pcr += 4;
    end
    flush = 1; drive(0, '0, '0); tick(); flush = 0;
    ready_in = 0;
    drive(1, 32'h2000, 32'hA); tick();
    drive(1, 32'h2004, 32'hB); tick();
    drive(1, 32'h2008, 32'hC);
    chk("prereset_count", 80'(count), 80'(2));
    reset = 0; tick(); reset = 1; drive(0, '0, '0);
    chk("midreset_count", 80'(count), 80'(0));
    chk("midreset_valid", 80'(valid_out), 80'(0));
    tick();
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Decode-side receiver of the fetch→decode valid/ready interface: buffers instruction/PC pairs from fetch and presents them in order to decode.
- Absorbs decode stalls so fetch keeps streaming while decode holds `ready` low.
- Sits between fetch (producer) and decode (consumer).
- Discards all buffered entries on a branch redirect (`flush`).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of the instruction and PC fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- flush  in  1  branch redirect (driven from take_branch); drops all entries.
- instr_in  in  XLEN  instruction from fetch (instr_to_decode).
- pc_in  in  XLEN  PC from fetch (pc_to_decode).
- valid_in  in  1  fetch has an entry this cycle.
- ready_out  out  1  queue can accept an entry; drives fetch's ready.
- instr_out  out  XLEN  head instruction to decode.
- pc_out  out  XLEN  head PC to decode.
- valid_out  out  1  head entry valid.
- ready_in  in  1  decode accepts the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- State: entry storage (instr, pc) × DEPTH; rd_ptr and wr_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH; count register.
- Reset (reset==0 at posedge):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs are then valid_out=0, ready_out=1, count=0, instr_out=0, pc_out=0.
  - Storage contents need not be cleared.
- Reset has priority over flush, push and pop.
- push = valid_in && ready_out.
  - On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = valid_out && ready_in.
  - On pop, rd_ptr increments.
- count update: +1 on push only, −1 on pop only, unchanged when push and pop occur together.
- ready_out = (count != DEPTH). It depends only on registered count, with no combinational path from ready_in.
  - When full, a same-cycle pop does not allow a push; ready_out stays 0 that cycle.
- valid_out = (count != 0).
- instr_out / pc_out:
  - Driven from storage at rd_ptr when count != 0.
  - Forced to 0 when count == 0.
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N, i.e. one cycle later. There is no same-cycle bypass.
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - Allowed whenever 0 < count < DEPTH.
  - When count==0, only a push can happen, since valid_out=0.
- Flush (flush==1 at posedge, reset==1):
  - rd_ptr = wr_ptr = count = 0.
  - Any same-cycle push and pop are ignored.
  - After the edge: valid_out=0, ready_out=1.
  - The first entry accepted after flush appears one cycle after its push.
- Stall: while ready_in==0, the head outputs and count stay stable. The queue keeps accepting entries until full.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no gaps or reordering.
- count never exceeds DEPTH and never underflows. A pop with count==0 is impossible by construction.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with valid_in=1 → valid_out=0, ready_out=1, count=0, instr_out=0, pc_out=0. Release, then push pc=0x0/instr=0x00000013 → next cycle valid_out=1, pc_out=0x0.
2. Streaming with ready_in=1, pushing pc=0x0..0x1C (instr=imem words) every cycle → outputs follow in order with one-cycle lag; count stays at 1; ready_out stays 1.
3. Backpressure, DEPTH=4, ready_in=0, pushing pc=0x0,0x4,0x8,0xC:
   - count reaches 4, ready_out=0.
   - A 5th entry pc=0x10 is held and not accepted.
   - Head stays pc=0x0.
   - Raise ready_in → outputs 0x0, 0x4, 0x8, 0xC, 0x10 in order.
4. Full with simultaneous pop: count=4, ready_in=1, valid_in=1 → only the pop happens that cycle; count goes to 3. The next cycle pushes and pops together, holding count=3.
5. Flush: count=3 (pc=0x20,0x24,0x28), with flush=1 and valid_in=1 pc=0x2C in the same cycle → next cycle count=0, valid_out=0. Then push pc=0x100, pc=0x104 → outputs 0x100, then 0x104.
6. Wrap and reset mid-operation:
   - Push/pop more than 3×DEPTH entries with random ready_in → order is preserved across pointer wrap.
   - Assert reset=0 with count=2 → next cycle count=0, valid_out=0.
